// File: rtl/rv32_branch_pkg.sv
// Shared definitions for the rv32 branch resolution unit: op encodings and link offset.
package rv32_branch_pkg;

    localparam int OP_W = 4;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_BEQ  = 4'b0000;
    localparam op_t OP_BNE  = 4'b0001;
    localparam op_t OP_BLT  = 4'b0100;
    localparam op_t OP_BGE  = 4'b0101;
    localparam op_t OP_BLTU = 4'b0110;
    localparam op_t OP_BGEU = 4'b0111;
    localparam op_t OP_JAL  = 4'b1000;
    localparam op_t OP_JALR = 4'b1001;

    localparam int LINK_OFFSET = 4;

endpackage

// File: rtl/branch_cmp.sv
// Combinational taken decision for conditional branches and unconditional jumps.
module branch_cmp
    import rv32_branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  op_t             op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (rs1 == rs2);
    assign lt_s = ($signed(rs1) < $signed(rs2));
    assign lt_u = (rs1 < rs2);

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = ~eq;
            OP_BLT:  taken = lt_s;
            OP_BGE:  taken = ~lt_s;
            OP_BLTU: taken = lt_u;
            OP_BGEU: taken = ~lt_u;
            OP_JAL:  taken = 1'b1;
            OP_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Pipelined branch/jump resolution: taken, target, link and misalignment per op,
// with valid/ready on both sides, flush, and 1 or 2 register stages.
module branch_unit
    import rv32_branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int PIPE      = 1,
    parameter int IMM_SHIFT = 1,
    parameter int IALIGN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  op_t             in_op,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_taken,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_link,
    output logic            out_misalign
);

    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] calc_target;
    logic [XLEN-1:0] calc_link;

    assign br_target   = in_pc + (in_imm << IMM_SHIFT);
    assign jalr_sum    = in_rs1 + in_imm;
    assign jalr_target = jalr_sum & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign calc_target = (in_op == OP_JALR) ? jalr_target : br_target;
    assign calc_link   = in_pc + XLEN'(LINK_OFFSET);

    // Operands feeding the output stage: straight from the inputs, or from stage 1.
    logic            pre_valid;
    op_t             pre_op;
    logic [XLEN-1:0] pre_rs1;
    logic [XLEN-1:0] pre_rs2;
    logic [XLEN-1:0] pre_target;
    logic [XLEN-1:0] pre_link;
    logic            pre_taken;
    logic            pre_misalign;
    logic            out_free;

    assign out_free = ~out_valid | out_ready;

    generate
        if (PIPE == 1) begin : g_pipe1
            assign in_ready   = rst_n & ~flush & out_free;
            assign pre_valid  = in_valid & in_ready;
            assign pre_op     = in_op;
            assign pre_rs1    = in_rs1;
            assign pre_rs2    = in_rs2;
            assign pre_target = calc_target;
            assign pre_link   = calc_link;
        end else begin : g_pipe2
            logic            s1_valid;
            op_t             s1_op;
            logic [XLEN-1:0] s1_rs1;
            logic [XLEN-1:0] s1_rs2;
            logic [XLEN-1:0] s1_target;
            logic [XLEN-1:0] s1_link;
            logic            s1_free;

            // Stage 1 may reload whenever its current op moves into the output stage.
            assign s1_free  = ~s1_valid | out_free;
            assign in_ready = rst_n & ~flush & s1_free;

            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    s1_valid  <= 1'b0;
                    s1_op     <= '0;
                    s1_rs1    <= '0;
                    s1_rs2    <= '0;
                    s1_target <= '0;
                    s1_link   <= '0;
                end else if (flush) begin
                    s1_valid <= 1'b0;
                end else if (s1_free) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_op     <= in_op;
                        s1_rs1    <= in_rs1;
                        s1_rs2    <= in_rs2;
                        s1_target <= calc_target;
                        s1_link   <= calc_link;
                    end
                end
            end

            assign pre_valid  = s1_valid;
            assign pre_op     = s1_op;
            assign pre_rs1    = s1_rs1;
            assign pre_rs2    = s1_rs2;
            assign pre_target = s1_target;
            assign pre_link   = s1_link;
        end
    endgenerate

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .op    (pre_op),
        .rs1   (pre_rs1),
        .rs2   (pre_rs2),
        .taken (pre_taken)
    );

    assign pre_misalign = pre_taken & ((IALIGN == 16) ? pre_target[0] : pre_target[1]);

    // Output registers only change when empty or drained, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_taken    <= 1'b0;
            out_target   <= '0;
            out_link     <= '0;
            out_misalign <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (out_free) begin
            out_valid <= pre_valid;
            if (pre_valid) begin
                out_taken    <= pre_taken;
                out_target   <= pre_target;
                out_link     <= pre_link;
                out_misalign <= pre_misalign;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: one PIPE=1 and one PIPE=2 instance share clock, reset and operands.
module tb_branch_unit;
    import rv32_branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        out_ready;
    logic        v1, v2;
    op_t         op;
    logic [31:0] pc, imm, rs1, rs2;

    logic        r1, ov1, tk1, mis1;
    logic [31:0] tg1, lk1;
    logic        r2, ov2, tk2, mis2;
    logic [31:0] tg2, lk2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        op_t         op;
        logic [31:0] pc, imm, rs1, rs2;
        logic        taken;
        logic [31:0] target, link;
        logic        mis;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    branch_unit #(.XLEN(32), .PIPE(1), .IMM_SHIFT(1), .IALIGN(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v1), .in_ready(r1),
        .in_op(op), .in_pc(pc), .in_imm(imm), .in_rs1(rs1), .in_rs2(rs2),
        .out_valid(ov1), .out_ready(out_ready), .out_taken(tk1), .out_target(tg1),
        .out_link(lk1), .out_misalign(mis1)
    );

    branch_unit #(.XLEN(32), .PIPE(2), .IMM_SHIFT(1), .IALIGN(32)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v2), .in_ready(r2),
        .in_op(op), .in_pc(pc), .in_imm(imm), .in_rs1(rs1), .in_rs2(rs2),
        .out_valid(ov2), .out_ready(out_ready), .out_taken(tk2), .out_target(tg2),
        .out_link(lk2), .out_misalign(mis2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input op_t o, input logic [31:0] p, input logic [31:0] i,
                          input logic [31:0] a, input logic [31:0] b);
        op = o; pc = p; imm = i; rs1 = a; rs2 = b;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; v1 = 1'b1; v2 = 1'b1;
        set_op(OP_JAL, 32'h100, 32'h8, 32'h0, 32'h0);
        #1;
        checks++;
        if ({r1, r2} !== 2'b00) begin
            errors++; $display("FAIL reset_in_ready got %b exp 00", {r1, r2});
        end
        tick; tick;
        checks++;
        if ({ov1, tk1, tg1, lk1, mis1} !== '0) begin
            errors++; $display("FAIL reset_out1 got v=%b t=%b tg=%h lk=%h m=%b exp all 0", ov1, tk1, tg1, lk1, mis1);
        end
        checks++;
        if ({ov2, tk2, tg2, lk2, mis2} !== '0) begin
            errors++; $display("FAIL reset_out2 got v=%b t=%b tg=%h lk=%h m=%b exp all 0", ov2, tk2, tg2, lk2, mis2);
        end
        v1 = 1'b0; v2 = 1'b0; rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        set_op(OP_BEQ, 32'h100, 32'h8, 32'h5, 32'h5);
        v1 = 1'b1;
        tick;
        v1 = 1'b0;
        checks++;
        if ({ov1, tk1, tg1, lk1, mis1} !== {1'b1, 1'b1, 32'h110, 32'h104, 1'b0}) begin
            errors++; $display("FAIL basic_beq got v=%b t=%b tg=%h lk=%h m=%b exp v=1 t=1 tg=110 lk=104 m=0", ov1, tk1, tg1, lk1, mis1);
        end
        tick;
        checks++;
        if (ov1 !== 1'b0) begin
            errors++; $display("FAIL basic_drain got %b exp 0", ov1);
        end
    endtask

    task automatic test_compare;
        vecs[0]  = '{OP_BLT,  32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h220, 32'h204, 1'b0};
        vecs[1]  = '{OP_BLTU, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h220, 32'h204, 1'b0};
        vecs[2]  = '{OP_BGEU, 32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b1, 32'h220, 32'h204, 1'b0};
        vecs[3]  = '{OP_BGE,  32'h200, 32'h10, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h220, 32'h204, 1'b0};
        vecs[4]  = '{OP_BNE,  32'h200, 32'h10, 32'h7, 32'h7, 1'b0, 32'h220, 32'h204, 1'b0};
        vecs[5]  = '{4'b0010, 32'h200, 32'h10, 32'h7, 32'h7, 1'b0, 32'h220, 32'h204, 1'b0};
        vecs[6]  = '{OP_BEQ,  32'h200, 32'h1, 32'h7, 32'h7, 1'b1, 32'h202, 32'h204, 1'b1};
        vecs[7]  = '{OP_BNE,  32'h200, 32'h1, 32'h7, 32'h7, 1'b0, 32'h202, 32'h204, 1'b0};
        vecs[8]  = '{OP_JALR, 32'h200, 32'h2, 32'h1003, 32'h0, 1'b1, 32'h1004, 32'h204, 1'b0};
        vecs[9]  = '{OP_JALR, 32'h200, 32'h2, 32'h1000, 32'h0, 1'b1, 32'h1002, 32'h204, 1'b1};
        vecs[10] = '{OP_JAL,  32'hFFFFFFFC, 32'h4, 32'h0, 32'h0, 1'b1, 32'h4, 32'h0, 1'b0};
        vecs[11] = '{OP_BGE,  32'h200, 32'h10, 32'h5, 32'h5, 1'b1, 32'h220, 32'h204, 1'b0};
        vecs[12] = '{4'hF,    32'h200, 32'h1, 32'h1, 32'h2, 1'b0, 32'h202, 32'h204, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            set_op(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].rs1, vecs[i].rs2);
            v1 = 1'b1;
            tick;
            checks++;
            if ({ov1, tk1, tg1, lk1, mis1} !== {1'b1, vecs[i].taken, vecs[i].target, vecs[i].link, vecs[i].mis}) begin
                errors++;
                $display("FAIL compare_%0d got v=%b t=%b tg=%h lk=%h m=%b exp v=1 t=%b tg=%h lk=%h m=%b",
                         i, ov1, tk1, tg1, lk1, mis1, vecs[i].taken, vecs[i].target, vecs[i].link, vecs[i].mis);
            end
        end
        v1 = 1'b0;
        tick;
    endtask

    task automatic test_backpressure1;
        out_ready = 1'b0;
        set_op(OP_BEQ, 32'h300, 32'h4, 32'h9, 32'h9);
        v1 = 1'b1;
        #1;
        checks++;
        if (r1 !== 1'b1) begin
            errors++; $display("FAIL bp1_ready_empty got %b exp 1", r1);
        end
        tick;
        set_op(OP_BNE, 32'h400, 32'h4, 32'h9, 32'h9);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({ov1, tk1, tg1, r1} !== {1'b1, 1'b1, 32'h308, 1'b0}) begin
                errors++; $display("FAIL bp1_hold_%0d got v=%b t=%b tg=%h rdy=%b exp v=1 t=1 tg=308 rdy=0", c, ov1, tk1, tg1, r1);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (r1 !== 1'b1) begin
            errors++; $display("FAIL bp1_ready_release got %b exp 1", r1);
        end
        tick;
        checks++;
        if ({ov1, tk1, tg1} !== {1'b1, 1'b0, 32'h408}) begin
            errors++; $display("FAIL bp1_second got v=%b t=%b tg=%h exp v=1 t=0 tg=408", ov1, tk1, tg1);
        end
        set_op(OP_JAL, 32'h500, 32'h10, 32'h0, 32'h0);
        tick;
        v1 = 1'b0;
        checks++;
        if ({ov1, tk1, tg1} !== {1'b1, 1'b1, 32'h520}) begin
            errors++; $display("FAIL bp1_third got v=%b t=%b tg=%h exp v=1 t=1 tg=520", ov1, tk1, tg1);
        end
        tick;
        checks++;
        if (ov1 !== 1'b0) begin
            errors++; $display("FAIL bp1_empty got %b exp 0", ov1);
        end
    endtask

    task automatic test_backpressure2;
        out_ready = 1'b0;
        set_op(OP_BEQ, 32'h300, 32'h4, 32'h9, 32'h9);
        v2 = 1'b1;
        tick;
        checks++;
        if ({ov2, r2} !== 2'b01) begin
            errors++; $display("FAIL bp2_latency got v=%b rdy=%b exp v=0 rdy=1", ov2, r2);
        end
        set_op(OP_BNE, 32'h400, 32'h4, 32'h9, 32'h9);
        tick;
        set_op(OP_JAL, 32'h500, 32'h10, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if ({ov2, tk2, tg2, r2} !== {1'b1, 1'b1, 32'h308, 1'b0}) begin
                errors++; $display("FAIL bp2_hold_%0d got v=%b t=%b tg=%h rdy=%b exp v=1 t=1 tg=308 rdy=0", c, ov2, tk2, tg2, r2);
            end
            tick;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (r2 !== 1'b1) begin
            errors++; $display("FAIL bp2_ready_release got %b exp 1", r2);
        end
        tick;
        v2 = 1'b0;
        checks++;
        if ({ov2, tk2, tg2} !== {1'b1, 1'b0, 32'h408}) begin
            errors++; $display("FAIL bp2_second got v=%b t=%b tg=%h exp v=1 t=0 tg=408", ov2, tk2, tg2);
        end
        tick;
        checks++;
        if ({ov2, tk2, tg2} !== {1'b1, 1'b1, 32'h520}) begin
            errors++; $display("FAIL bp2_third got v=%b t=%b tg=%h exp v=1 t=1 tg=520", ov2, tk2, tg2);
        end
        tick;
        checks++;
        if (ov2 !== 1'b0) begin
            errors++; $display("FAIL bp2_empty got %b exp 0", ov2);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b1;
        set_op(OP_BEQ, 32'h300, 32'h4, 32'h9, 32'h9);
        v2 = 1'b1;
        tick;
        set_op(OP_BNE, 32'h400, 32'h4, 32'h9, 32'h9);
        tick;
        checks++;
        if ({ov2, tg2} !== {1'b1, 32'h308}) begin
            errors++; $display("FAIL flush_pre got v=%b tg=%h exp v=1 tg=308", ov2, tg2);
        end
        flush = 1'b1;
        set_op(OP_JAL, 32'h600, 32'h10, 32'h0, 32'h0);
        #1;
        checks++;
        if (r2 !== 1'b0) begin
            errors++; $display("FAIL flush_in_ready got %b exp 0", r2);
        end
        tick;
        flush = 1'b0;
        v2 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (ov2 !== 1'b0) begin
                errors++; $display("FAIL flush_quiet_%0d got %b exp 0", c, ov2);
            end
            tick;
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b1;
        set_op(OP_JAL, 32'h500, 32'h10, 32'h0, 32'h0);
        v1 = 1'b1; v2 = 1'b1;
        tick; tick;
        checks++;
        if ({ov1, tg1, ov2, tg2} !== {1'b1, 32'h520, 1'b1, 32'h520}) begin
            errors++; $display("FAIL midrst_pre got v1=%b tg1=%h v2=%b tg2=%h exp 1 520 1 520", ov1, tg1, ov2, tg2);
        end
        rst_n = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if ({r1, r2} !== 2'b00) begin
            errors++; $display("FAIL midrst_in_ready got %b exp 00", {r1, r2});
        end
        tick;
        checks++;
        if ({ov1, tk1, tg1, lk1, mis1, ov2, tk2, tg2, lk2, mis2} !== '0) begin
            errors++; $display("FAIL midrst_out got tg1=%h lk1=%h tg2=%h lk2=%h v=%b%b exp all 0", tg1, lk1, tg2, lk2, ov1, ov2);
        end
        rst_n = 1'b1; flush = 1'b0; v1 = 1'b0; v2 = 1'b0;
        tick;
        checks++;
        if ({ov1, ov2} !== 2'b00) begin
            errors++; $display("FAIL midrst_after got %b exp 00", {ov1, ov2});
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_compare;
        test_backpressure1;
        test_backpressure2;
        test_flush;
        test_reset_midstream;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
